// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states, BCD digit type, default sync word and digit validity helper
package bcd_pkg;
  typedef enum logic [2:0] {HUNT, OPCODE, LOAD_A, LOAD_B, COMPUTE, DONE} state_t;
  typedef logic [3:0] bcd_digit_t;
  localparam logic [7:0] SYNC_DEFAULT = 8'b01011010;
  function automatic logic has_bad_digit(input logic [31:0] v);
    has_bad_digit = 1'b0;
    for (int i = 0; i < 8; i++) has_bad_digit |= v[4*i+:4] > 4'd9;
  endfunction
endpackage

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder: combinational single-digit BCD add with carry in/out
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t sum,
  output logic       cout
);
  logic [4:0] s;
  assign s    = {1'b0, a} + {1'b0, b} + {4'b0, cin};
  assign cout = s > 5'd9;
  assign sum  = cout ? s[3:0] + 4'd6 : s[3:0];
endmodule

// File: rtl/bcd_serial_alu.sv
// bcd_serial_alu: serial-framed BCD add/sub with sync hunt, digit-serial compute and ready/valid output
module bcd_serial_alu
  import bcd_pkg::*;
#(
  parameter int                DIGITS       = 4,
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = SYNC_W'(SYNC_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [4*DIGITS-1:0] result,
  output logic                carry_out,
  output logic                digit_err,
  output logic                op_sub,
  output logic                out_valid,
  input  logic                out_ready
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(W);
  state_t state, state_d;
  logic [SYNC_W-1:0] win, win_d;
  logic [CW-1:0] cnt;
  logic [W-1:0] a, b, acc, acc_d;
  logic opc, c, cout, take, last_bit, last_dig;
  bcd_digit_t b_dig, sum;
  assign din_ready = state inside {HUNT, OPCODE, LOAD_A, LOAD_B};
  assign out_valid = state == DONE;
  assign take      = din_valid && din_ready;
  assign win_d     = SYNC_W'({win, din});
  assign last_bit  = cnt == CW'(W - 1);
  assign last_dig  = cnt == CW'(DIGITS - 1);
  assign b_dig     = opc ? 4'd9 - b[3:0] : b[3:0];
  assign acc_d     = W'({sum, acc} >> 4);
  bcd_digit_adder u_add (.a(a[3:0]), .b(b_dig), .cin(c), .sum(sum), .cout(cout));
  always_comb begin
    state_d = state;
    case (state)
      HUNT:    if (take && win_d == SYNC_PATTERN) state_d = OPCODE;
      OPCODE:  if (take) state_d = LOAD_A;
      LOAD_A:  if (take && last_bit) state_d = LOAD_B;
      LOAD_B:  if (take && last_bit) state_d = COMPUTE;
      COMPUTE: if (last_dig) state_d = DONE;
      DONE:    if (out_ready) state_d = HUNT;
      default: state_d = HUNT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= HUNT;
    else state <= state_d;
  // operands rotate one digit per compute cycle so digit 0 always sits in [3:0]
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win       <= '0;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      acc       <= '0;
      opc       <= 1'b0;
      c         <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      digit_err <= 1'b0;
      op_sub    <= 1'b0;
    end else begin
      case (state)
        HUNT:   if (take) win <= win_d;
        OPCODE: if (take) opc <= din;
        LOAD_A: if (take) begin
          a   <= W'({a, din});
          cnt <= last_bit ? '0 : cnt + CW'(1);
        end
        LOAD_B: if (take) begin
          b   <= W'({b, din});
          cnt <= last_bit ? '0 : cnt + CW'(1);
          c   <= opc;
        end
        COMPUTE: begin
          a   <= W'({a, a} >> 4);
          b   <= W'({b, b} >> 4);
          acc <= acc_d;
          c   <= cout;
          cnt <= last_dig ? '0 : cnt + CW'(1);
          if (last_dig) begin
            result    <= acc_d;
            carry_out <= cout ^ opc;
            digit_err <= has_bad_digit(32'(a)) | has_bad_digit(32'(b));
            op_sub    <= opc;
          end
        end
        DONE:    if (out_ready) win <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_alu.sv
// tb_bcd_serial_alu: scoreboard bench for the serial BCD ALU
module tb_bcd_serial_alu;
  localparam int DIGITS = 4;
  localparam logic [7:0] SYNC = 8'b01011010;
  typedef struct packed {logic [15:0] res; logic cy; logic err; logic sub;} exp_t;
  logic clk = 0, reset_n = 0, din = 0, din_valid = 0, out_ready = 1;
  logic din_ready, carry_out, digit_err, op_sub, out_valid;
  logic [15:0] result;
  exp_t sb[$];
  int checks = 0, errors = 0;
  bcd_serial_alu #(.DIGITS(DIGITS), .SYNC_W(8), .SYNC_PATTERN(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .result(result), .carry_out(carry_out), .digit_err(digit_err), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i+:4]);
    return r;
  endfunction
  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic exp_t model(input logic sub, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int ai = bcd2int(a), bi = bcd2int(b), s;
    e.err = 1'b0;
    for (int i = 0; i < 4; i++) e.err |= (a[4*i+:4] > 4'd9) || (b[4*i+:4] > 4'd9);
    e.sub = sub;
    s = sub ? ai - bi : ai + bi;
    e.cy = sub ? (s < 0) : (s >= 10000);
    e.res = int2bcd(s < 0 ? s + 10000 : s % 10000);
    return e;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output result=%h carry=%b", result, carry_out);
      end else begin
        e = sb.pop_front();
        if ((!e.err && (result !== e.res || carry_out !== e.cy)) || digit_err !== e.err || op_sub !== e.sub) begin
          errors++;
          $display("FAIL result got res=%h cy=%b err=%b sub=%b expected res=%h cy=%b err=%b sub=%b",
                   result, carry_out, digit_err, op_sub, e.res, e.cy, e.err, e.sub);
        end
      end
    end
  end
  task automatic send_bit(input logic v, input int gap);
    int t = 0;
    repeat (gap) begin
      din = ~v;
      din_valid = 0;
      @(posedge clk); #1;
    end
    while (!din_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 200) begin
      checks++;
      errors++;
      $display("FAIL din_ready_timeout got 0 expected 1");
    end
    din = v;
    din_valid = 1;
    @(posedge clk); #1;
    din_valid = 0;
    din = 0;
  endtask
  task automatic send_frame(input logic sub, input logic [15:0] a, input logic [15:0] b, input bit gaps);
    for (int i = 7; i >= 0; i--) send_bit(SYNC[i], 0);
    send_bit(sub, 0);
    for (int i = 15; i >= 0; i--) send_bit(a[i], (gaps && i % 4 == 1) ? 3 : 0);
    for (int i = 15; i >= 0; i--) send_bit(b[i], 0);
    sb.push_back(model(sub, a, b));
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", sb.size());
    end
  endtask
  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({result, carry_out, digit_err, op_sub, out_valid} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", {result, carry_out, digit_err, op_sub, out_valid});
    end
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_din_ready got %b expected 1", din_ready);
    end
  endtask
  task automatic test_latency();
    int n = 0;
    send_frame(0, 16'h1234, 16'h5678, 0);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      if (!out_valid) n++;
    end
    checks++;
    if (n !== DIGITS) begin
      errors++;
      $display("FAIL latency got %0d idle cycles expected %0d", n, DIGITS);
    end
    drain();
  endtask
  task automatic test_back_to_back();
    send_frame(0, 16'h9999, 16'h0001, 0);
    send_frame(1, 16'h0100, 16'h0001, 0);
    send_frame(1, 16'h0001, 16'h0002, 0);
    send_frame(1, 16'h4321, 16'h4321, 0);
    for (int k = 0; k < 6; k++)
      send_frame(1'($urandom_range(0, 1)), int2bcd($urandom_range(0, 9999)), int2bcd($urandom_range(0, 9999)), 0);
    drain();
  endtask
  task automatic test_overlap_sync();
    send_bit(0, 0); send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
    send_frame(0, 16'h0777, 16'h0333, 0);
    drain();
  endtask
  task automatic test_gaps();
    send_frame(0, 16'h1234, 16'h5678, 1);
    send_frame(1, 16'h2000, 16'h0999, 1);
    drain();
  endtask
  task automatic test_digit_err();
    send_frame(0, 16'h00A0, 16'h0001, 0);
    send_frame(0, 16'h0050, 16'h0001, 0);
    drain();
  endtask
  task automatic test_backpressure();
    logic [15:0] r;
    int t = 0;
    out_ready = 0;
    send_frame(0, 16'h0042, 16'h0058, 0);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    r = result;
    for (int k = 0; k < 10; k++) begin
      din_valid = 1;
      din = k[0];
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || din_ready !== 1'b0 || result !== r) begin
        errors++;
        $display("FAIL hold got valid=%b ready=%b res=%h expected 1 0 %h", out_valid, din_ready, result, r);
      end
    end
    @(posedge clk); #1;
    din_valid = 0;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || din_ready !== 1'b1 || result !== r) begin
      errors++;
      $display("FAIL release got valid=%b ready=%b res=%h expected 0 1 %h", out_valid, din_ready, result, r);
    end
    drain();
  endtask
  task automatic test_reset_mid_frame();
    int seen = 0;
    logic [15:0] a = 16'h1111, b = 16'h2222;
    for (int i = 7; i >= 0; i--) send_bit(SYNC[i], 0);
    send_bit(0, 0);
    for (int i = 15; i >= 0; i--) send_bit(a[i], 0);
    for (int i = 15; i >= 8; i--) send_bit(b[i], 0);
    reset_n = 0;
    @(negedge clk);
    checks++;
    if ({result, carry_out, digit_err, op_sub, out_valid} !== 20'h0) begin
      errors++;
      $display("FAIL midreset_outputs got %h expected 0", {result, carry_out, digit_err, op_sub, out_valid});
    end
    @(posedge clk); #1;
    reset_n = 1;
    for (int i = 7; i >= 0; i--) send_bit(b[i], 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL aborted_frame out_valid cycles got %0d expected 0", seen);
    end
    send_frame(0, 16'h0808, 16'h0192, 0);
    drain();
  endtask
  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_overlap_sync();
    test_gaps();
    test_digit_err();
    test_backpressure();
    test_reset_mid_frame();
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
